// File: rtl/renkon_ctrl.sv
// Layer sequencer for a multi-core convolution engine: streams one shared weight and image read
// sequence per (group, channel), with registered valid strobes that line up with 1-cycle reads.
module renkon_ctrl #(
  parameter int unsigned CORE    = 8,
  parameter int unsigned LWIDTH  = 10,
  parameter int unsigned IMGSIZE = 12,
  parameter int unsigned NETSIZE = 11
) (
  input  logic               clk,
  input  logic               xrst,
  input  logic               req,
  input  logic [LWIDTH-1:0]  total_out,
  input  logic [LWIDTH-1:0]  total_in,
  input  logic [LWIDTH-1:0]  img_size,
  input  logic [LWIDTH-1:0]  fil_size,
  input  logic [IMGSIZE-1:0] input_addr,
  output logic               ack,
  output logic [NETSIZE-1:0] mem_net_addr,
  output logic               net_valid,
  output logic [LWIDTH-1:0]  net_idx,
  output logic [IMGSIZE-1:0] mem_img_addr,
  output logic               pixel_valid,
  output logic               first_in,
  output logic               last_in,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StNet, StImg, StDone} state_e;

  localparam logic [LWIDTH-1:0]  LOne  = LWIDTH'(1);
  localparam logic [IMGSIZE-1:0] IOne  = IMGSIZE'(1);
  localparam logic [NETSIZE-1:0] NOne  = NETSIZE'(1);
  localparam logic [LWIDTH:0]    CoreW = (LWIDTH + 1)'(CORE);

  state_e state_q, state_d;
  logic [LWIDTH-1:0]  cfg_out_q, cfg_out_d, cfg_in_q, cfg_in_d;
  logic [LWIDTH-1:0]  cfg_img_q, cfg_img_d, cfg_fil_q, cfg_fil_d;
  logic [IMGSIZE-1:0] base_q, base_d, img_ptr_q, img_ptr_d;
  logic [NETSIZE-1:0] net_ptr_q, net_ptr_d;
  logic [LWIDTH-1:0]  fy_q, fy_d, fx_q, fx_d, tap_q, tap_d;
  logic [LWIDTH-1:0]  y_q, y_d, x_q, x_d, chan_q, chan_d, out_cnt_q, out_cnt_d;
  logic               ack_q, ack_d, net_valid_q, pixel_valid_q, first_q, last_q;
  logic [LWIDTH-1:0]  net_idx_q;
  logic               zero_cfg, last_grp;

  assign zero_cfg = (total_out == '0) || (total_in == '0) || (img_size == '0) ||
                    (fil_size == '0);
  // Widened by one bit so out_cnt + CORE cannot wrap before the compare.
  assign last_grp = ({1'b0, out_cnt_q} + CoreW) >= {1'b0, cfg_out_q};

  always_comb begin
    state_d   = state_q;
    cfg_out_d = cfg_out_q;
    cfg_in_d  = cfg_in_q;
    cfg_img_d = cfg_img_q;
    cfg_fil_d = cfg_fil_q;
    base_d    = base_q;
    img_ptr_d = img_ptr_q;
    net_ptr_d = net_ptr_q;
    fy_d      = fy_q;
    fx_d      = fx_q;
    tap_d     = tap_q;
    y_d       = y_q;
    x_d       = x_q;
    chan_d    = chan_q;
    out_cnt_d = out_cnt_q;
    ack_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          cfg_out_d = total_out;
          cfg_in_d  = total_in;
          cfg_img_d = img_size;
          cfg_fil_d = fil_size;
          base_d    = input_addr;
          img_ptr_d = input_addr;
          net_ptr_d = '0;
          fy_d      = '0;
          fx_d      = '0;
          tap_d     = '0;
          y_d       = '0;
          x_d       = '0;
          chan_d    = '0;
          out_cnt_d = '0;
          state_d   = zero_cfg ? StDone : StNet;
        end
      end
      StNet: begin
        net_ptr_d = net_ptr_q + NOne;
        tap_d     = tap_q + LOne;
        if (fx_q == cfg_fil_q - LOne) begin
          fx_d = '0;
          if (fy_q == cfg_fil_q - LOne) begin
            fy_d    = '0;
            tap_d   = '0;
            state_d = StImg;
          end else begin
            fy_d = fy_q + LOne;
          end
        end else begin
          fx_d = fx_q + LOne;
        end
      end
      StImg: begin
        img_ptr_d = img_ptr_q + IOne;
        if (x_q == cfg_img_q - LOne) begin
          x_d = '0;
          if (y_q == cfg_img_q - LOne) begin
            y_d = '0;
            if (chan_q != cfg_in_q - LOne) begin
              chan_d  = chan_q + LOne;
              state_d = StNet;
            end else if (!last_grp) begin
              out_cnt_d = out_cnt_q + CoreW[LWIDTH-1:0];
              chan_d    = '0;
              img_ptr_d = base_q;
              state_d   = StNet;
            end else begin
              state_d = StDone;
            end
          end else begin
            y_d = y_q + LOne;
          end
        end else begin
          x_d = x_q + LOne;
        end
      end
      StDone: begin
        ack_d   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q       <= StIdle;
      cfg_out_q     <= '0;
      cfg_in_q      <= '0;
      cfg_img_q     <= '0;
      cfg_fil_q     <= '0;
      base_q        <= '0;
      img_ptr_q     <= '0;
      net_ptr_q     <= '0;
      fy_q          <= '0;
      fx_q          <= '0;
      tap_q         <= '0;
      y_q           <= '0;
      x_q           <= '0;
      chan_q        <= '0;
      out_cnt_q     <= '0;
      ack_q         <= 1'b0;
      net_valid_q   <= 1'b0;
      net_idx_q     <= '0;
      pixel_valid_q <= 1'b0;
      first_q       <= 1'b0;
      last_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cfg_out_q     <= cfg_out_d;
      cfg_in_q      <= cfg_in_d;
      cfg_img_q     <= cfg_img_d;
      cfg_fil_q     <= cfg_fil_d;
      base_q        <= base_d;
      img_ptr_q     <= img_ptr_d;
      net_ptr_q     <= net_ptr_d;
      fy_q          <= fy_d;
      fx_q          <= fx_d;
      tap_q         <= tap_d;
      y_q           <= y_d;
      x_q           <= x_d;
      chan_q        <= chan_d;
      out_cnt_q     <= out_cnt_d;
      ack_q         <= ack_d;
      // Strobes trail the address phase by one cycle to match the memory read latency.
      net_valid_q   <= (state_q == StNet);
      net_idx_q     <= (state_q == StNet) ? tap_q : '0;
      pixel_valid_q <= (state_q == StImg);
      first_q       <= (state_q == StImg) && (chan_q == '0);
      last_q        <= (state_q == StImg) && (chan_q == cfg_in_q - LOne);
    end
  end

  assign ack          = ack_q;
  assign busy         = (state_q != StIdle);
  assign mem_net_addr = net_ptr_q;
  assign mem_img_addr = img_ptr_q;
  assign net_valid    = net_valid_q;
  assign net_idx      = net_idx_q;
  assign pixel_valid  = pixel_valid_q;
  assign first_in     = first_q;
  assign last_in      = last_q;

endmodule

// File: tb/tb_renkon_ctrl.sv
// Randomized bench for renkon_ctrl: a per-layer list of expected read phases is built from the
// layer arithmetic, then every cycle of the DUT is compared against it.
module tb_renkon_ctrl;
  localparam int unsigned CORE = 8, LW = 10, IS = 12, NS = 11;

  logic          clk = 1'b0, xrst = 1'b0, req = 1'b0;
  logic [LW-1:0] total_out = '0, total_in = '0, img_size = '0, fil_size = '0;
  logic [IS-1:0] input_addr = '0;
  logic          ack, net_valid, pixel_valid, first_in, last_in, busy;
  logic [NS-1:0] mem_net_addr;
  logic [LW-1:0] net_idx;
  logic [IS-1:0] mem_img_addr;

  renkon_ctrl #(.CORE(CORE), .LWIDTH(LW), .IMGSIZE(IS), .NETSIZE(NS)) dut (
    .clk(clk), .xrst(xrst), .req(req), .total_out(total_out), .total_in(total_in),
    .img_size(img_size), .fil_size(fil_size), .input_addr(input_addr), .ack(ack),
    .mem_net_addr(mem_net_addr), .net_valid(net_valid), .net_idx(net_idx),
    .mem_img_addr(mem_img_addr), .pixel_valid(pixel_valid), .first_in(first_in),
    .last_in(last_in), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int q_kind[$], q_addr[$], q_idx[$], q_first[$], q_last[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".ack"}, ack, 0);
    check({tag, ".net_valid"}, net_valid, 0);
    check({tag, ".pixel_valid"}, pixel_valid, 0);
    check({tag, ".first_in"}, first_in, 0);
    check({tag, ".last_in"}, last_in, 0);
    check({tag, ".net_addr"}, mem_net_addr, 0);
    check({tag, ".img_addr"}, mem_img_addr, 0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge one cycle after ack.
  // poke_t < 0 picks a random busy cycle for a spurious req; abort_t > 0 resets mid-layer.
  task automatic run_layer(input int tout, input int tin, input int isz, input int fsz,
                           input int base, input int poke_t, input int abort_t);
    int groups, na, n;
    q_kind.delete(); q_addr.delete(); q_idx.delete(); q_first.delete(); q_last.delete();
    groups = (tout == 0 || tin == 0 || isz == 0 || fsz == 0) ? 0 : (tout + CORE - 1) / CORE;
    na = 0;
    for (int g = 0; g < groups; g++) begin
      for (int c = 0; c < tin; c++) begin
        for (int k = 0; k < fsz * fsz; k++) begin
          q_kind.push_back(0); q_addr.push_back(na % (1 << NS)); q_idx.push_back(k);
          q_first.push_back(0); q_last.push_back(0);
          na++;
        end
        for (int p = 0; p < isz * isz; p++) begin
          q_kind.push_back(1); q_addr.push_back((base + c * isz * isz + p) % (1 << IS));
          q_idx.push_back(0); q_first.push_back(c == 0); q_last.push_back(c == tin - 1);
        end
      end
    end
    n = q_kind.size();
    if (poke_t < 0) poke_t = $urandom_range(1, n + 1);
    total_out = LW'(tout); total_in = LW'(tin); img_size = LW'(isz); fil_size = LW'(fsz);
    input_addr = IS'(base);
    req = 1'b1;
    @(negedge clk);
    for (int t = 1; t <= n + 3; t++) begin
      int e, v;
      e = t - 1;
      v = t - 2;
      check("busy", busy, t <= n + 1);
      check("ack", ack, t == n + 2);
      if (e < n) begin
        if (q_kind[e] == 0) check("net_addr", mem_net_addr, q_addr[e]);
        else check("img_addr", mem_img_addr, q_addr[e]);
      end
      if (v >= 0 && v < n) begin
        check("net_valid", net_valid, q_kind[v] == 0);
        check("pixel_valid", pixel_valid, q_kind[v] == 1);
        if (q_kind[v] == 0) check("net_idx", net_idx, q_idx[v]);
        else begin
          check("first_in", first_in, q_first[v]);
          check("last_in", last_in, q_last[v]);
        end
      end else begin
        check("net_valid_idle", net_valid, 0);
        check("pixel_valid_idle", pixel_valid, 0);
      end
      req = (t == poke_t);
      total_out = LW'($urandom); total_in = LW'($urandom); img_size = LW'($urandom);
      fil_size = LW'($urandom); input_addr = IS'($urandom);
      if (t == abort_t) begin
        #2 xrst = 1'b0;
        #1 check_quiet("abort");
        req = 1'b0;
        @(negedge clk);
        check_quiet("abort_hold");
        @(negedge clk);
        xrst = 1'b1;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    req = 1'b0;
  endtask

  initial begin
    #3 check_quiet("reset");
    @(negedge clk);
    xrst = 1'b1;
    @(negedge clk);
    run_layer(8, 1, 4, 3, 100, 0, 0);       // single group, 9 taps + 16 pixels
    run_layer(16, 2, 2, 1, 100, 0, 0);      // two groups, two channels
    run_layer(9, 1, 2, 2, 0, 0, 0);         // ceil(9/8) = 2 groups
    run_layer(0, 1, 2, 2, 0, 0, 0);         // zero config: straight to done
    run_layer(8, 1, 4, 3, 100, 15, 0);      // spurious req during image phase
    run_layer(16, 1, 2, 2, 100, 0, 10);     // reset during group 1 weight phase
    run_layer(16, 1, 2, 2, 100, 0, 0);
    run_layer(8, 1, 4, 3, 100, 0, 0);
    run_layer(8, 1, 2, 1, 4094, 0, 0);      // image address wrap
    for (int i = 0; i < 25; i++) begin
      int tout, tin, isz, fsz, ab;
      tout = $urandom_range(0, 20);
      tin  = $urandom_range(0, 3);
      isz  = $urandom_range(0, 4);
      fsz  = $urandom_range(0, 3);
      ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
      run_layer(tout, tin, isz, fsz, $urandom_range(0, 4095), -1, ab);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
